bp_update_queue: RTL and testbench

BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

---
 rtl/bp_update_queue.sv | 153 +++++++++++++++
 tb/tb_bp_update_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// bp_update_queue
// In-order retirement queue for predicted branches. Fetch allocates a slot
// per predicted branch (capturing its PC and the base predictor's 2-bit
// counter value); execute resolves slots out of order; resolved slots retire
// from the head in program order as one-cycle predictor update strobes.
// A mispredict squashes every slot younger than the resolved one.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alloc_valid/pc/pred      allocation request from fetch
//   alloc_ready, alloc_tag   acceptance and slot index for the allocation
//   resolve_valid/tag/taken/mispredict   branch resolution from execute
//   update_valid/pc/taken/pred           registered predictor update
//   count                    number of occupied slots
module bp_update_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic [1:0]       alloc_pred,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             resolve_mispredict,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic [1:0]       update_pred,
  output logic [TAG_W:0]   count
);

  localparam int PTR_W = TAG_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d, taken_q, taken_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [1:0]       pred_q [DEPTH];
  logic [1:0]       pred_d [DEPTH];

  logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic [1:0]       upd_pred_q, upd_pred_d;

  logic [TAG_W-1:0] head_idx, tail_idx, res_off;
  logic             full, mispredict_req, alloc_fire, resolve_ok, pop;
  logic [DEPTH-1:0] younger;

  assign head_idx       = head_q[TAG_W-1:0];
  assign tail_idx       = tail_q[TAG_W-1:0];
  assign count          = tail_q - head_q;
  assign full           = (count == PTR_W'(DEPTH));
  // A mispredict request blocks allocation even if the resolve itself is
  // ignored; fetch is being redirected either way.
  assign mispredict_req = resolve_valid && resolve_mispredict;
  assign alloc_ready    = !full && !mispredict_req;
  assign alloc_tag      = tail_idx;
  assign alloc_fire     = alloc_valid && alloc_ready;
  assign resolve_ok     = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
  assign pop            = valid_q[head_idx] && resolved_q[head_idx];
  // Age of the resolved slot relative to the head; slots further from the
  // head than this are younger and get squashed on a mispredict.
  assign res_off        = resolve_tag - head_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = (TAG_W'(i) - head_idx) > res_off;
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    taken_d     = taken_q;
    pc_d        = pc_q;
    pred_d      = pred_q;
    upd_valid_d = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    upd_pred_d  = upd_pred_q;

    if (pop) begin
      valid_d[head_idx]    = 1'b0;
      resolved_d[head_idx] = 1'b0;
      head_d               = head_q + 1'b1;
      upd_valid_d          = 1'b1;
      upd_pc_d             = pc_q[head_idx];
      upd_taken_d          = taken_q[head_idx];
      upd_pred_d           = pred_q[head_idx];
    end

    if (resolve_ok) begin
      resolved_d[resolve_tag] = 1'b1;
      taken_d[resolve_tag]    = resolve_taken;
      if (resolve_mispredict) begin
        valid_d    = valid_d & ~younger;
        resolved_d = resolved_d & ~younger;
        // Rebuilding from the old head keeps the wrap bit consistent.
        tail_d     = head_q + PTR_W'(res_off) + 1'b1;
      end
    end

    if (alloc_fire) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      pc_d[tail_idx]       = alloc_pc;
      pred_d[tail_idx]     = alloc_pred;
      tail_d               = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      resolved_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_pred_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      upd_pred_q  <= upd_pred_d;
    end
  end

  // Payload storage is only meaningful under a valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    taken_q <= taken_d;
    pc_q    <= pc_d;
    pred_q  <= pred_d;
  end

  assign update_valid = upd_valid_q;
  assign update_pc    = upd_pc_q;
  assign update_taken = upd_taken_q;
  assign update_pred  = upd_pred_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue (DEPTH=8). Inputs change 1 ns after the
// rising edge; updates are captured on the falling edge into a queue of
// {taken, pred, pc} entries.
module tb_bp_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic [1:0]  alloc_pred;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        resolve_valid;
  logic [2:0]  resolve_tag;
  logic        resolve_taken;
  logic        resolve_mispredict;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [1:0]  update_pred;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] upd_q[$];

  bp_update_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_pred(update_pred),
    .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update_valid) upd_q.push_back({update_taken, update_pred, update_pc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=%0t exp=<200000", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] upd_at(input int i);
    if (upd_q.size() > i) return upd_q[i];
    return '1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_pc = '0; alloc_pred = '0;
    resolve_valid = 0; resolve_tag = '0; resolve_taken = 0; resolve_mispredict = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    upd_q.delete();
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [1:0] pred, input logic [2:0] exp_tag);
    alloc_valid = 1; alloc_pc = pc; alloc_pred = pred;
    #1;
    check("alloc_ready", alloc_ready, 1);
    check("alloc_tag", alloc_tag, exp_tag);
    step();
    alloc_valid = 0;
  endtask

  task automatic resolve(input logic [2:0] tag, input logic taken, input logic mp);
    resolve_valid = 1; resolve_tag = tag; resolve_taken = taken; resolve_mispredict = mp;
    step();
    resolve_valid = 0; resolve_mispredict = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // reset state
    check("rst_count", count, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_uvalid", update_valid, 0);
    check("rst_upc", update_pc, 0);
    check("rst_upred", update_pred, 0);

    // single branch, N+2 latency
    alloc(32'h100, 2'd2, 3'd0);
    resolve(3'd0, 1'b1, 1'b0);
    check("t1_n1_uvalid", update_valid, 0);
    step();
    check("t1_n2_uvalid", update_valid, 1);
    check("t1_n2_upc", update_pc, 32'h100);
    check("t1_n2_utaken", update_taken, 1);
    check("t1_n2_upred", update_pred, 2);
    check("t1_n2_count", count, 0);
    step();
    check("t1_n3_uvalid", update_valid, 0);
    check("t1_hold_upc", update_pc, 32'h100);

    // out-of-order resolve, in-order retire
    do_reset();
    alloc(32'h200, 2'd1, 3'd0);
    alloc(32'h204, 2'd1, 3'd1);
    alloc(32'h208, 2'd1, 3'd2);
    resolve(3'd2, 1'b1, 1'b0);
    resolve(3'd1, 1'b0, 1'b0);
    step(); step();
    check("t2_no_upd_yet", upd_q.size(), 0);
    resolve(3'd0, 1'b1, 1'b0);
    check("t2_n1_uvalid", update_valid, 0);
    repeat (4) step();
    check("t2_nupd", upd_q.size(), 3);
    check("t2_pc0", upd_at(0)[31:0], 32'h200);
    check("t2_pc1", upd_at(1)[31:0], 32'h204);
    check("t2_pc2", upd_at(2)[31:0], 32'h208);
    check("t2_taken1", upd_at(1)[34], 0);

    // full queue, blocked alloc, pop + alloc with tail wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'h300 + 32'(4 * i), 2'(i), 3'(i));
    check("t3_full_count", count, 8);
    check("t3_full_ready", alloc_ready, 0);
    alloc_valid = 1; alloc_pc = 32'h999;
    #1;
    check("t3_9th_ready", alloc_ready, 0);
    step();
    alloc_valid = 0;
    check("t3_9th_count", count, 8);
    resolve(3'd0, 1'b1, 1'b0);
    resolve_valid = 1; resolve_tag = 3'd1; resolve_taken = 1;
    #1;
    check("t3_popfull_ready", alloc_ready, 0);
    check("t3_popfull_count", count, 8);
    step();
    resolve_valid = 0;
    check("t3_after_pop_count", count, 7);
    alloc(32'hA00, 2'd3, 3'd0);
    check("t3_popalloc_count", count, 7);
    step();
    check("t3_nupd", upd_q.size(), 2);
    check("t3_pc0", upd_at(0)[31:0], 32'h300);
    check("t3_pc1", upd_at(1)[31:0], 32'h304);

    // mispredict squash with same-cycle alloc
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'h400 + 32'(4 * i), 2'd1, 3'(i));
    resolve_valid = 1; resolve_tag = 3'd1; resolve_taken = 0; resolve_mispredict = 1;
    alloc_valid = 1; alloc_pc = 32'hBAD;
    #1;
    check("t4_mp_ready", alloc_ready, 0);
    step();
    idle_inputs();
    check("t4_mp_count", count, 2);
    resolve(3'd2, 1'b1, 1'b0);
    resolve(3'd3, 1'b1, 1'b0);
    resolve(3'd4, 1'b1, 1'b0);
    check("t4_ignored_count", count, 2);
    check("t4_no_upd", upd_q.size(), 0);
    alloc(32'h500, 2'd0, 3'd2);
    check("t4_realloc_count", count, 3);
    resolve(3'd0, 1'b1, 1'b0);
    repeat (4) step();
    check("t4_nupd", upd_q.size(), 2);
    check("t4_pc0", upd_at(0)[31:0], 32'h400);
    check("t4_pc1", upd_at(1)[31:0], 32'h404);
    check("t4_taken1", upd_at(1)[34], 0);
    check("t4_end_count", count, 1);

    // resolve of empty slot and duplicate resolve
    do_reset();
    resolve(3'd3, 1'b1, 1'b0);
    check("t5_empty_count", count, 0);
    check("t5_empty_ready", alloc_ready, 1);
    alloc(32'h600, 2'd1, 3'd0);
    check("t5_count1", count, 1);
    resolve(3'd0, 1'b1, 1'b0);
    resolve(3'd0, 1'b0, 1'b0);
    repeat (3) step();
    check("t5_nupd", upd_q.size(), 1);
    check("t5_pc", upd_at(0)[31:0], 32'h600);
    check("t5_taken", upd_at(0)[34], 1);
    check("t5_pred", upd_at(0)[33:32], 1);
    check("t5_end_count", count, 0);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'h700 + 32'(4 * i), 2'd3, 3'(i));
    resolve(3'd1, 1'b1, 1'b0);
    resolve(3'd2, 1'b1, 1'b0);
    check("t6_pre_count", count, 5);
    rst = 1;
    alloc_valid = 1; alloc_pc = 32'h7FF;
    resolve_valid = 1; resolve_tag = 3'd0; resolve_taken = 1;
    step();
    rst = 0;
    idle_inputs();
    check("t6_count", count, 0);
    check("t6_ready", alloc_ready, 1);
    check("t6_uvalid", update_valid, 0);
    repeat (4) step();
    check("t6_nupd", upd_q.size(), 0);
    check("t6_upc", update_pc, 0);
    check("t6_end_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
